// File: rtl/rc5_encryptor.sv
// rc5_encryptor -- RC5-32/12 round engine.
// Reads the expanded subkey table S[0..T-1] one word at a time from a
// synchronous, read-only S memory. It applies pre-whitening plus R full
// rounds to one two-word block.
//
// Optional feature: define DECRYPT_EN to add the iDecrypt port and the
// inverse datapath. With DECRYPT_EN undefined the block encrypts only.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   iStart          start request, sampled only in IDLE or DONE
//   iPlainA/B       plaintext words, latched on the accepted iStart edge
//   iDecrypt        (DECRYPT_EN only) selects the inverse direction,
//                   latched with iStart
//   oS_address      registered S memory read address
//   iS_data         S memory read data, valid one cycle after the address
//   oCipherA/B      working registers A/B; hold the result once done
//   oBusy           high while a block is in flight (WAIT/APPLY)
//   oDone           result valid; level, held until the next accepted start
//   oDbgState       current FSM state (0 IDLE, 1 WAIT, 2 APPLY, 3 DONE)
//
// Handshake: a start is accepted on any rising edge where iStart=1 and the
// FSM is in IDLE or DONE. On that edge oDone falls and oBusy rises. oBusy
// falls and oDone rises together on the edge that applies the last S word.
// While oBusy=1, iStart is ignored.
module rc5_encryptor #(
  parameter int W        = 32,
  parameter int R        = 12,
  parameter int T        = 2 * R + 2,
  parameter int T_LENGTH = $clog2(T)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic [W-1:0]        iPlainA,
  input  logic [W-1:0]        iPlainB,
`ifdef DECRYPT_EN
  input  logic                iDecrypt,
`endif
  output logic [T_LENGTH-1:0] oS_address,
  input  logic [W-1:0]        iS_data,
  output logic [W-1:0]        oCipherA,
  output logic [W-1:0]        oCipherB,
  output logic                oBusy,
  output logic                oDone,
  output logic [1:0]          oDbgState
);

  localparam int LW = $clog2(W);
  localparam logic [T_LENGTH-1:0] K_LAST = T_LENGTH'(T - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_APPLY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [T_LENGTH-1:0] k_q, k_d;
  logic [T_LENGTH-1:0] addr_q, addr_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Barrel rotators: rotate a doubled word and keep the relevant half.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] s);
    logic [2*W-1:0] d;
    d = {x, x} << s;
    return d[2*W-1:W];
  endfunction

  // Encryption round results for the current word; only one is committed.
  logic [W-1:0] a_enc, b_enc;
  always_comb begin
    a_enc = (k_q == '0) ? a_q + iS_data
                        : rotl(a_q ^ b_q, b_q[LW-1:0]) + iS_data;
    b_enc = (k_q == T_LENGTH'(1)) ? b_q + iS_data
                                  : rotl(b_q ^ a_q, a_q[LW-1:0]) + iS_data;
  end

`ifdef DECRYPT_EN
  logic dec_q, dec_d;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LW-1:0] s);
    logic [2*W-1:0] d;
    d = {x, x} >> s;
    return d[W-1:0];
  endfunction

  logic [W-1:0] a_dec, b_dec;
  always_comb begin
    a_dec = (k_q == '0) ? a_q - iS_data
                        : rotr(a_q - iS_data, b_q[LW-1:0]) ^ b_q;
    b_dec = (k_q == T_LENGTH'(1)) ? b_q - iS_data
                                  : rotr(b_q - iS_data, a_q[LW-1:0]) ^ a_q;
  end

  // Decryption walks the table downwards and finishes at word 0.
  logic         is_last;
  logic [T_LENGTH-1:0] k_next;
  logic [W-1:0] a_new, b_new;
  assign is_last = dec_q ? (k_q == '0) : (k_q == K_LAST);
  assign k_next  = dec_q ? k_q - T_LENGTH'(1) : k_q + T_LENGTH'(1);
  assign a_new   = dec_q ? a_dec : a_enc;
  assign b_new   = dec_q ? b_dec : b_enc;
`else
  logic         is_last;
  logic [T_LENGTH-1:0] k_next;
  logic [W-1:0] a_new, b_new;
  assign is_last = (k_q == K_LAST);
  assign k_next  = k_q + T_LENGTH'(1);
  assign a_new   = a_enc;
  assign b_new   = b_enc;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef DECRYPT_EN
    dec_d   = dec_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (iStart) begin
          a_d     = iPlainA;
          b_d     = iPlainB;
          k_d     = '0;
          addr_d  = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_WAIT;
`ifdef DECRYPT_EN
          dec_d   = iDecrypt;
          if (iDecrypt) begin
            k_d    = K_LAST;
            addr_d = K_LAST;
          end
`endif
        end
      end
      // One idle cycle covers the S memory read latency.
      S_WAIT: state_d = S_APPLY;
      S_APPLY: begin
        // Even words update A, odd words update B.
        if (k_q[0]) b_d = b_new;
        else        a_d = a_new;
        if (is_last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          k_d     = k_next;
          addr_d  = k_next;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DECRYPT_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DECRYPT_EN
      dec_q   <= dec_d;
`endif
    end
  end

  assign oS_address = addr_q;
  assign oCipherA   = a_q;
  assign oCipherB   = b_q;
  assign oBusy      = busy_q;
  assign oDone      = done_q;
  assign oDbgState  = state_q;

endmodule

// File: tb/tb_rc5_encryptor.sv
// Testbench for rc5_encryptor. Drivers issue blocks and push the expected
// ciphertext and completion cycle into queues. A monitor pops the queues on
// every rising oDone and compares the popped values with the DUT outputs.
module tb_rc5_encryptor;
  localparam int W  = 32;
  localparam int R  = 12;
  localparam int T  = 2 * R + 2;
  localparam int TL = $clog2(T);
  localparam int LAT = 2 * T;
  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iStart = 1'b0;
  logic [W-1:0]  iPlainA = '0;
  logic [W-1:0]  iPlainB = '0;
  logic [W-1:0]  iS_data = '0;
  logic [TL-1:0] oS_address;
  logic [W-1:0]  oCipherA, oCipherB;
  logic          oBusy, oDone;
  logic [1:0]    oDbgState;
`ifdef DECRYPT_EN
  logic          iDecrypt = 1'b0;
`endif

  rc5_encryptor #(.W(W), .R(R)) dut (
    .clk(clk), .rst(rst), .iStart(iStart),
    .iPlainA(iPlainA), .iPlainB(iPlainB),
`ifdef DECRYPT_EN
    .iDecrypt(iDecrypt),
`endif
    .oS_address(oS_address), .iS_data(iS_data),
    .oCipherA(oCipherA), .oCipherB(oCipherB),
    .oBusy(oBusy), .oDone(oDone), .oDbgState(oDbgState)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous S memory model: data one cycle after the address.
  logic [W-1:0] s_mem [T];
  always @(posedge clk) iS_data <= s_mem[oS_address];

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [31:0] s);
    logic [4:0] r;
    r = s[4:0];
    return (x << r) | (x >> (6'd32 - {1'b0, r}));
  endfunction

  task automatic load_zero_s();
    for (int i = 0; i < T; i++) s_mem[i] = '0;
  endtask

  // RC5 key schedule for an all-zero 16-byte key.
  task automatic load_zero_key_s();
    logic [31:0] l [4];
    logic [31:0] a, b;
    int i, j;
    s_mem[0] = P32;
    for (int t = 1; t < T; t++) s_mem[t] = s_mem[t-1] + Q32;
    for (int t = 0; t < 4; t++) l[t] = '0;
    a = '0; b = '0; i = 0; j = 0;
    for (int n = 0; n < 3 * T; n++) begin
      a = rotl32(s_mem[i] + a + b, 32'd3);
      s_mem[i] = a;
      b = rotl32(l[j] + a + b, a + b);
      l[j] = b;
      i = (i + 1) % T;
      j = (j + 1) % 4;
    end
  endtask

  function automatic logic [63:0] model_enc(input logic [31:0] pa, input logic [31:0] pb);
    logic [31:0] a, b;
    a = pa + s_mem[0];
    b = pb + s_mem[1];
    for (int i = 1; i <= R; i++) begin
      a = rotl32(a ^ b, b) + s_mem[2*i];
      b = rotl32(b ^ a, a) + s_mem[2*i+1];
    end
    return {a, b};
  endfunction

  // ---------------- monitor ----------------
  logic           done_prev = 1'b0;
  logic [2*W-1:0] mon_exp;
  int             mon_cyc;
  always @(negedge clk) begin
    if (oDone && !done_prev) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got oDone=1 expected no result pending (cycle %0d)", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("cipher", {oCipherA, oCipherB}, mon_exp);
        check("done_cycle", 64'(cyc), 64'(mon_cyc));
      end
    end
    done_prev = oDone;
  end

  // ---------------- driver tasks ----------------
  // Presents a start and returns the number of the edge that accepted it.
  task automatic issue_start(input logic [31:0] pa, input logic [31:0] pb,
                             input logic dec, output int e0);
    @(negedge clk);
    iStart  = 1'b1;
    iPlainA = pa;
    iPlainB = pb;
`ifdef DECRYPT_EN
    iDecrypt = dec;
`else
    if (dec) $display("decrypt request ignored in encrypt-only build");
`endif
    @(negedge clk);
    e0 = cyc;
    iStart = 1'b0;
  endtask

  task automatic expect_result(input logic [63:0] v, input int done_cyc);
    exp_q.push_back(v);
    exp_cyc_q.push_back(done_cyc);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int e0;
  int exp_addr;
  logic [31:0] pt_a [3];
  logic [31:0] pt_b [3];

  initial begin
    pt_a[0] = 32'h00000000; pt_b[0] = 32'h00000000;
    pt_a[1] = 32'h01234567; pt_b[1] = 32'h89ABCDEF;
    pt_a[2] = 32'hFFFFFFFF; pt_b[2] = 32'h00000001;
    load_zero_s();

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_done", 64'(oDone), 64'd0);
    check("rst_cipher", {oCipherA, oCipherB}, 64'd0);
    check("rst_addr", 64'(oS_address), 64'd0);
    rst = 1'b0;

    // All-zero S table: address sweep, busy window and latency.
    issue_start(32'h0, 32'h0, 1'b0, e0);
    expect_result(64'd0, e0 + LAT);
    for (int i = 0; i <= LAT; i++) begin
      exp_addr = (i < LAT) ? i / 2 : T - 1;
      check("sweep_addr", 64'(oS_address), 64'(exp_addr));
      check("sweep_busy", 64'(oBusy), (i < LAT) ? 64'd1 : 64'd0);
      if (i < LAT) check("early_done", 64'(oDone), 64'd0);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("done_held", 64'(oDone), 64'd1);

    // Known vector; a second start at word 5 must be ignored.
    load_zero_key_s();
    issue_start(32'h0, 32'h0, 1'b0, e0);
    expect_result({32'hEEDBA521, 32'h6D8F4B15}, e0 + LAT);
    wait_until(e0 + 11);
    iStart = 1'b1; iPlainA = 32'hDEADBEEF; iPlainB = 32'hCAFEF00D;
    @(negedge clk);
    iStart = 1'b0;
    check("busy_after_ignored_start", 64'(oBusy), 64'd1);
    wait_until(e0 + LAT + 2);

    // Asynchronous reset while word 10 is being applied.
    issue_start(32'h11111111, 32'h22222222, 1'b0, e0);
    expect_result(model_enc(32'h11111111, 32'h22222222), e0 + LAT);
    wait_until(e0 + 21);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(oBusy), 64'd0);
    check("midrst_done", 64'(oDone), 64'd0);
    check("midrst_cipher", {oCipherA, oCipherB}, 64'd0);
    check("midrst_addr", 64'(oS_address), 64'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    issue_start(32'h0, 32'h0, 1'b0, e0);
    expect_result({32'hEEDBA521, 32'h6D8F4B15}, e0 + LAT);
    wait_until(e0 + LAT + 2);

    // iStart held high: one result every 2T+1 cycles.
    @(negedge clk);
    iStart = 1'b1; iPlainA = pt_a[0]; iPlainB = pt_b[0];
    @(negedge clk);
    e0 = cyc;
    expect_result(model_enc(pt_a[0], pt_b[0]), e0 + LAT);
    for (int b = 1; b < 3; b++) begin
      wait_until(e0 + LAT);
      iPlainA = pt_a[b]; iPlainB = pt_b[b];
      @(negedge clk);
      check("done_one_cycle", 64'(oDone), 64'd0);
      check("restart_busy", 64'(oBusy), 64'd1);
      e0 = e0 + LAT + 1;
      expect_result(model_enc(pt_a[b], pt_b[b]), e0 + LAT);
    end
    wait_until(e0 + LAT);
    iStart = 1'b0;
    repeat (2) @(negedge clk);
    check("last_done_held", 64'(oDone), 64'd1);

`ifdef DECRYPT_EN
    // Inverse of the known vector, walking the table downwards.
    issue_start(32'hEEDBA521, 32'h6D8F4B15, 1'b1, e0);
    expect_result(64'd0, e0 + LAT);
    for (int i = 0; i <= LAT; i++) begin
      exp_addr = (i < LAT) ? (T - 1) - i / 2 : 0;
      check("dec_addr", 64'(oS_address), 64'(exp_addr));
      @(negedge clk);
    end
    iDecrypt = 1'b0;
    repeat (2) @(negedge clk);
`endif

    check("results_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rc5_encryptor.md
# rc5_encryptor

Round engine for the RC5-32/12 datapath, directly downstream of the key-mixing stage. Once key mixing completes, it reads the expanded subkey table S[0..T-1] from the shared S memory, one word at a time. It runs pre-whitening plus R full rounds on one 2-word block and presents the ciphertext with a done flag.

## Interface
Parameters:
- W, 32, word width; rotate amount uses the low $clog2(W) bits.
- R, 12, number of rounds.
- T, 2*R+2 (derived, 26), S-table depth.
- T_LENGTH, $clog2(T) (derived), S address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- iStart  in  1  start request; sampled only in IDLE or DONE.
- iPlainA  in  W  plaintext word A; latched on the accepted iStart edge.
- iPlainB  in  W  plaintext word B; latched on the accepted iStart edge.
- oS_address  out  T_LENGTH  S memory read address (registered).
- iS_data  in  W  S memory read data; synchronous memory, valid one cycle after oS_address updates.
- oCipherA  out  W  result word A (working register A).
- oCipherB  out  W  result word B (working register B).
- oBusy  out  1  high in WAIT and APPLY.
- oDone  out  1  result valid; level, held until next accepted iStart or reset.

## Operation
- Reset (async): state=IDLE, k=0, oS_address=0, oCipherA=oCipherB=0, oBusy=0, oDone=0.
- States: IDLE, WAIT, APPLY, DONE.
- IDLE/DONE with iStart=1:
  - A<=iPlainA, B<=iPlainB, k<=0, oS_address<=0, oDone<=0, oBusy<=1.
  - Go to WAIT.
- WAIT: hold all registers for one cycle (memory latency), then go to APPLY.
- APPLY: consume iS_data for word k. All arithmetic is mod 2^W; rotations are left rotations.
  - k=0: A<=A+S[0].
  - k=1: B<=B+S[1].
  - k even, k>=2: A<=((A^B)<<<B[log2W-1:0])+S[k].
  - k odd, k>=3: B<=((B^A)<<<A[log2W-1:0])+S[k].
  - If k==T-1: go to DONE, oDone<=1, oBusy<=0, oS_address unchanged.
  - Else: k<=k+1, oS_address<=k+1, go to WAIT.
- iStart while busy (WAIT/APPLY) is ignored; plaintext is not re-latched.
- iStart in DONE restarts immediately; oDone drops on that edge.
- The rotator is combinational (barrel). It is applied in the same APPLY cycle as the XOR and the add.
- S memory is read-only from this block; no write enable is driven.

## Timing
- Accepted iStart edge = e0. Word k is applied at edge e0+2(k+1).
- Last word is applied at e0+2T (52 for T=26). oDone and the ciphertext are valid from that edge.
- oS_address = k throughout the WAIT/APPLY pair for word k.
- Back-to-back throughput: one block per 2T+1 cycles, with iStart held high in DONE.
- Reset asserted mid-operation aborts the block immediately. All outputs return to reset values, with no partial oDone.

## Configuration
- DECRYPT_EN defined:
  - Adds port iDecrypt (in, 1), latched with iStart.
  - When latched high, k starts at T-1 and decrements; oS_address follows k.
  - Odd k>=3: B<=((B-S[k])>>>A[log2W-1:0])^A.
  - Even k>=2: A<=((A-S[k])>>>B[log2W-1:0])^B.
  - k=1: B<=B-S[1].
  - k=0: A<=A-S[0]; DONE after k=0.
  - Latency is identical to encryption.
- DECRYPT_EN undefined: no iDecrypt port; encryption only; no subtractor or right rotator is synthesized.

## Test plan
- Reset mid-block: assert rst at word k=10 -> oBusy=0, oDone=0, oCipherA=oCipherB=0, oS_address=0 asynchronously; next iStart restarts cleanly.
- S all zero, iPlainA=0, iPlainB=0 -> oDone rises exactly 52 cycles after the start edge, oCipherA=0, oCipherB=0; oS_address sweeps 0..25, each value held 2 cycles.
- S from the bench model's RC5-32/12/16 key expansion of an all-zero 16-byte key, iPlainA=iPlainB=0 -> oCipherA=32'hEEDBA521, oCipherB=32'h6D8F4B15.
- iStart pulsed again at word k=5 with different plaintext -> ignored; result matches the first plaintext.
- iStart held high continuously -> oDone high for exactly 1 cycle every 53 cycles; each result matches the model.
- DECRYPT_EN build: decrypt the ciphertext from the known-vector scenario (iDecrypt=1) -> oCipherA=0, oCipherB=0; oS_address sweeps 25 down to 0.
